// File: rtl/week6_ex1_xor_frame_parity_pkg.sv
// ============================================================================
// Module : week6_ex1_xor_frame_parity_pkg
// Brief  : Shared types for the week-6 frame-parity block. Holds the FSM
//          state encoding used by the top and by later handshake blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package week6_ex1_xor_frame_parity_pkg;

  // Width of the state register.
  localparam int STATE_W = 2;

  // FSM state encoding. These values are shared with the other week-6
  // handshake blocks, so they must not be renumbered.
  //   S_IDLE  : waiting for the first word of a frame
  //   S_ACCUM : frame in progress, folding words into the accumulator
  //   S_HOLD  : frame complete, result held until the sink takes it
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

endpackage : week6_ex1_xor_frame_parity_pkg

`default_nettype wire

// File: rtl/week6_xor_accum_reg.sv
// ============================================================================
// Module : week6_xor_accum_reg
// Brief  : WIDTH-bit XOR accumulator register. It can be cleared, loaded
//          with a fresh word, or XOR-folded with the incoming word.
//          Priority, highest first: clear, load, xor_en.
// Ports  : clk       - clock, rising edge
//          rst_n     - asynchronous active-low reset (acc -> 0)
//          clear_i   - synchronous clear (acc -> 0)
//          load_i    - acc <= data_i
//          xor_en_i  - acc <= acc ^ data_i
//          data_i    - incoming word
//          acc_o     - current accumulator value
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module week6_xor_accum_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             xor_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] acc_q;

  // The accumulator has no guard bits. XOR cannot overflow, so the register
  // stays exactly WIDTH bits wide. Unknown bits on data_i are not masked:
  // they propagate into acc_q, so a corrupted source is visible downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= data_i;
    end else if (xor_en_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign acc_o = acc_q;

endmodule : week6_xor_accum_reg

`default_nettype wire

// File: rtl/week6_ex1_xor_frame_parity.sv
// ============================================================================
// Module : week6_ex1_xor_frame_parity
// Brief  : Streaming frame parity generator/checker. Folds FRAME_LEN
//          consecutive WIDTH-bit words together with XOR and presents the
//          XOR word plus a parity bit. Both sides use a valid/ready
//          handshake.
// Params : WIDTH      - data word width (>=1)
//          FRAME_LEN  - words per frame (>=1)
//          ODD_PARITY - 0: out_parity = ^out_word, 1: out_parity = ~^out_word
// Ports  : clk, rst_n          - clock / asynchronous active-low reset
//          clr                 - synchronous frame abort; beats accept/deliver
//          in_valid/in_data    - word source
//          in_ready            - a word can be accepted this cycle
//          out_valid/out_ready - frame-result handshake
//          out_word/out_parity - frame XOR and its parity
//          word_count          - words accepted in the current frame
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module week6_ex1_xor_frame_parity
  import week6_ex1_xor_frame_parity_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FRAME_LEN  = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_word,
  output logic                           out_parity,
  output logic [$clog2(FRAME_LEN+1)-1:0] word_count
);

  localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  // Count value at which the accepted word completes the frame.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  // A one-word frame skips ACCUM and goes straight to HOLD.
  localparam state_e            FIRST_NEXT = (FRAME_LEN == 1) ? S_HOLD : S_ACCUM;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             acc_clear;
  logic             acc_load;
  logic             acc_xor;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             deliver;

  // --------------------------------------------------------------------------
  // Handshake decode. in_ready and out_valid depend only on state, so there
  // is no combinational path from the inputs to either handshake output.
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid = (state_q == S_HOLD);

  // clr wins over both handshakes: a word offered together with clr is
  // dropped, and a pending result is discarded rather than delivered.
  assign accept  = in_valid  & in_ready  & ~clr;
  assign deliver = out_valid & out_ready & ~clr;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and accumulator controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_xor   = 1'b0;

    if (clr) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      acc_clear = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The first word loads the accumulator directly. This makes the
          // result independent of whatever acc held before the frame.
          if (accept) begin
            acc_load = 1'b1;
            cnt_d    = CNT_ONE;
            state_d  = FIRST_NEXT;
          end
        end

        S_ACCUM: begin
          // Gap cycles (no accept) leave both acc and cnt untouched.
          if (accept) begin
            acc_xor = 1'b1;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_d = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (deliver) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            acc_clear = 1'b1;
          end
        end

        default: begin
          // The unused encoding recovers to a clean, empty frame.
          state_d   = S_IDLE;
          cnt_d     = '0;
          acc_clear = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator
  // --------------------------------------------------------------------------
  week6_xor_accum_reg #(
    .WIDTH (WIDTH)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (acc_clear),
    .load_i   (acc_load),
    .xor_en_i (acc_xor),
    .data_i   (in_data),
    .acc_o    (acc)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The result is only exposed in HOLD. Partial sums are never visible, so
  // out_word reads zero outside HOLD. Under reset this also makes out_parity
  // equal to ODD_PARITY.
  assign out_word   = (state_q == S_HOLD) ? acc : '0;
  assign out_parity = ODD_PARITY ? ~^out_word : ^out_word;
  assign word_count = cnt_q;

endmodule : week6_ex1_xor_frame_parity

`default_nettype wire

// File: tb/tb_week6_ex1_xor_frame_parity.sv
// ============================================================================
// Module : tb_week6_ex1_xor_frame_parity
// Brief  : Directed self-checking bench for week6_ex1_xor_frame_parity.
//          dut0: WIDTH=8, FRAME_LEN=4, even parity
//          dut1: same stimulus as dut0, odd parity
//          dut2: WIDTH=8, FRAME_LEN=1, own stimulus
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_week6_ex1_xor_frame_parity;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_parity0;
  logic [7:0] out_word0;
  logic [2:0] word_count0;

  logic       in_ready1, out_valid1, out_parity1;
  logic [7:0] out_word1;
  logic [2:0] word_count1;

  logic       f_clr, f_in_valid, f_out_ready;
  logic [7:0] f_in_data;
  logic       f_in_ready, f_out_valid, f_out_parity;
  logic [7:0] f_out_word;
  logic       f_word_count;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  week6_ex1_xor_frame_parity #(.WIDTH(8), .FRAME_LEN(4), .ODD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_word(out_word0), .out_parity(out_parity0), .word_count(word_count0)
  );

  week6_ex1_xor_frame_parity #(.WIDTH(8), .FRAME_LEN(4), .ODD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_word(out_word1), .out_parity(out_parity1), .word_count(word_count1)
  );

  week6_ex1_xor_frame_parity #(.WIDTH(8), .FRAME_LEN(1), .ODD_PARITY(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .in_valid(f_in_valid), .in_data(f_in_data),
    .in_ready(f_in_ready), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_word(f_out_word), .out_parity(f_out_parity), .word_count(f_word_count)
  );

  // Reset with in_valid high, then release.
  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    f_clr = 1'b0; f_in_valid = 1'b0; f_in_data = 8'h00; f_out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
    checks++; if (out_word0 !== 8'h00) begin errors++; $display("FAIL reset_out_word: got %h expected 00", out_word0); end
    checks++; if (word_count0 !== 3'd0) begin errors++; $display("FAIL reset_word_count: got %0d expected 0", word_count0); end
    checks++; if (out_parity0 !== 1'b0) begin errors++; $display("FAIL reset_parity_even: got %b expected 0", out_parity0); end
    checks++; if (out_parity1 !== 1'b1) begin errors++; $display("FAIL reset_parity_odd: got %b expected 1", out_parity1); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
  endtask

  // Frame A5,3C,FF,00 back-to-back -> 66.
  task automatic test_frame();
    logic [7:0] w [4];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (word_count0 !== 3'(i)) begin errors++; $display("FAIL frame_count: got %0d expected %0d", word_count0, i); end
      in_valid = 1'b1; in_data = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL frame_out_valid: got %b expected 1", out_valid0); end
    checks++; if (out_word0 !== 8'h66) begin errors++; $display("FAIL frame_out_word: got %h expected 66", out_word0); end
    checks++; if (out_parity0 !== 1'b0) begin errors++; $display("FAIL frame_parity_even: got %b expected 0", out_parity0); end
    checks++; if (out_parity1 !== 1'b1) begin errors++; $display("FAIL frame_parity_odd: got %b expected 1", out_parity1); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL frame_in_ready_hold: got %b expected 0", in_ready0); end
    checks++; if (word_count0 !== 3'd4) begin errors++; $display("FAIL frame_count_full: got %0d expected 4", word_count0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL frame_valid_one_cycle: got %b expected 0", out_valid0); end
    checks++; if (out_word0 !== 8'h00) begin errors++; $display("FAIL frame_word_idle: got %h expected 00", out_word0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL frame_in_ready_idle: got %b expected 1", in_ready0); end
    checks++; if (word_count0 !== 3'd0) begin errors++; $display("FAIL frame_count_idle: got %0d expected 0", word_count0); end
  endtask

  // Held result under backpressure, EE ignored, next frame clean.
  task automatic test_backpressure();
    logic [7:0] w [4];
    logic [7:0] v [4];
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    v = '{8'h10, 8'h20, 8'h40, 8'h80};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      @(negedge clk);
    end
    in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_word0 !== 8'h66) begin errors++; $display("FAIL bp_hold_word: got %h expected 66", out_word0); end
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready0); end
      @(negedge clk);
    end
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b expected 1", out_valid0); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_delivered: got %b expected 0", out_valid0); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = v[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_word0 !== 8'hF0) begin errors++; $display("FAIL bp_next_word: got %h expected f0", out_word0); end
    checks++; if (out_parity0 !== 1'b0) begin errors++; $display("FAIL bp_next_parity: got %b expected 0", out_parity0); end
    @(negedge clk);
  endtask

  // Partial frame aborted by clr (with a word offered), then a gapped frame.
  task automatic test_gaps_clr();
    logic [7:0] w [4];
    w = '{8'h01, 8'h02, 8'h04, 8'h08};
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; @(negedge clk);
    in_data = 8'h22; @(negedge clk);
    checks++; if (word_count0 !== 3'd2) begin errors++; $display("FAIL clr_pre_count: got %0d expected 2", word_count0); end
    clr = 1'b1; in_data = 8'h33; @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (word_count0 !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", word_count0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b expected 0", out_valid0); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'hC3;
      checks++; if (word_count0 !== 3'(i + 1)) begin errors++; $display("FAIL gap_count: got %0d expected %0d", word_count0, i + 1); end
      if (i == 3) begin
        checks++; if (out_word0 !== 8'h0F) begin errors++; $display("FAIL gap_out_word: got %h expected 0f", out_word0); end
        checks++; if (out_parity0 !== 1'b0) begin errors++; $display("FAIL gap_parity: got %b expected 0", out_parity0); end
      end
      @(negedge clk);
      if (i < 3) begin
        checks++; if (word_count0 !== 3'(i + 1)) begin errors++; $display("FAIL gap_hold_count: got %0d expected %0d", word_count0, i + 1); end
      end
    end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL gap_delivered: got %b expected 0", out_valid0); end
  endtask

  // Async reset mid-frame, then a fresh frame.
  task automatic test_async_reset();
    logic [7:0] p [3];
    logic [7:0] w [4];
    p = '{8'h12, 8'h34, 8'h56};
    w = '{8'h80, 8'h01, 8'h00, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = p[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (word_count0 !== 3'd3) begin errors++; $display("FAIL ar_pre_count: got %0d expected 3", word_count0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (word_count0 !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", word_count0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b expected 0", out_valid0); end
    checks++; if (out_word0 !== 8'h00) begin errors++; $display("FAIL ar_out_word: got %h expected 00", out_word0); end
    checks++; if (out_parity1 !== 1'b1) begin errors++; $display("FAIL ar_parity_odd: got %b expected 1", out_parity1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_word0 !== 8'h81) begin errors++; $display("FAIL ar_next_word: got %h expected 81", out_word0); end
    checks++; if (out_parity0 !== 1'b0) begin errors++; $display("FAIL ar_next_parity: got %b expected 0", out_parity0); end
    checks++; if (out_parity1 !== 1'b1) begin errors++; $display("FAIL ar_next_parity_odd: got %b expected 1", out_parity1); end
    @(negedge clk);
  endtask

  // FRAME_LEN=1: every word is its own frame.
  task automatic test_frame_len1();
    f_out_ready = 1'b1;
    f_in_valid = 1'b1; f_in_data = 8'h07;
    @(negedge clk);
    f_in_data = 8'hFE;
    checks++; if (f_out_valid !== 1'b1) begin errors++; $display("FAIL fl1_valid_a: got %b expected 1", f_out_valid); end
    checks++; if (f_out_word !== 8'h07) begin errors++; $display("FAIL fl1_word_a: got %h expected 07", f_out_word); end
    checks++; if (f_out_parity !== 1'b1) begin errors++; $display("FAIL fl1_parity_a: got %b expected 1", f_out_parity); end
    checks++; if (f_in_ready !== 1'b0) begin errors++; $display("FAIL fl1_in_ready_hold: got %b expected 0", f_in_ready); end
    checks++; if (f_word_count !== 1'b1) begin errors++; $display("FAIL fl1_count: got %0d expected 1", f_word_count); end
    @(negedge clk);
    checks++; if (f_out_valid !== 1'b0) begin errors++; $display("FAIL fl1_gap_valid: got %b expected 0", f_out_valid); end
    checks++; if (f_in_ready !== 1'b1) begin errors++; $display("FAIL fl1_gap_ready: got %b expected 1", f_in_ready); end
    @(negedge clk);
    f_in_valid = 1'b0;
    checks++; if (f_out_word !== 8'hFE) begin errors++; $display("FAIL fl1_word_b: got %h expected fe", f_out_word); end
    checks++; if (f_out_parity !== 1'b1) begin errors++; $display("FAIL fl1_parity_b: got %b expected 1", f_out_parity); end
    @(negedge clk);
    checks++; if (f_out_valid !== 1'b0) begin errors++; $display("FAIL fl1_done: got %b expected 0", f_out_valid); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_gaps_clr();
    test_async_reset();
    test_frame_len1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_week6_ex1_xor_frame_parity

`default_nettype wire
